// File: rtl/mips_run_monitor.sv
// Run controller/checker for MIPSProcessor: holds proc_reset, then passes on a stable matching result or times out.
// Latency: start-to-done is at least RST_CYCLES+STABLE_CYCLES cycles; all outputs registered except hist_data.
// No backpressure: start is ignored outside IDLE/DONE. Optional history buffer enabled by MIPS_MON_HIST_EN.
module mips_run_monitor #(
    parameter int RESULT_W      = 17,
    parameter int RST_CYCLES    = 2,
    parameter int MAX_CYCLES    = 50,
    parameter int STABLE_CYCLES = 4,
    parameter int HIST_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [RESULT_W-1:0]           expected,
    input  logic [RESULT_W-1:0]           result,
    output logic                          proc_reset,
    output logic                          running,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [15:0]                   cycle_count,
    output logic [7:0]                    change_count,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [RESULT_W-1:0]           hist_data
);
    localparam int HW = $clog2(STABLE_CYCLES + 1);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int IW = $clog2(HIST_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t              state, state_n;
    logic [RW-1:0]       rcnt, rcnt_n;
    logic [HW-1:0]       h, h_n;
    logic [RESULT_W-1:0] prev, prev_n;
    logic [15:0]         cc_n;
    logic [7:0]          chg_n;
    logic                done_n, pass_n, to_n;
    logic                push, clr;

    always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        h_n     = h;
        prev_n  = prev;
        cc_n    = cycle_count;
        chg_n   = change_count;
        done_n  = done;
        pass_n  = pass;
        to_n    = timeout;
        push    = 1'b0;
        clr     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_RESET;
                    clr     = 1'b1;
                    rcnt_n  = '0;
                    h_n     = '0;
                    cc_n    = '0;
                    chg_n   = '0;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    to_n    = 1'b0;
                end
            end
            S_RESET: begin
                if (rcnt == RW'(RST_CYCLES - 1)) state_n = S_RUN;
                else                             rcnt_n  = rcnt + RW'(1);
            end
            S_RUN: begin
                cc_n = cycle_count + 16'd1;
                // h==0 marks the first sample of a run
                if (h == '0) begin
                    h_n    = HW'(1);
                    prev_n = result;
                    push   = 1'b1;
                end else if (result == prev) begin
                    if (h != HW'(STABLE_CYCLES)) h_n = h + HW'(1);
                end else begin
                    h_n    = HW'(1);
                    prev_n = result;
                    push   = 1'b1;
                    if (change_count != 8'hFF) chg_n = change_count + 8'd1;
                end
                if (h_n == HW'(STABLE_CYCLES) && result == expected) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    pass_n  = 1'b1;
                end else if (cc_n == 16'(MAX_CYCLES)) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    to_n    = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rcnt         <= '0;
            h            <= '0;
            prev         <= '0;
            cycle_count  <= '0;
            change_count <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            proc_reset   <= 1'b1;
            running      <= 1'b0;
        end else begin
            state        <= state_n;
            rcnt         <= rcnt_n;
            h            <= h_n;
            prev         <= prev_n;
            cycle_count  <= cc_n;
            change_count <= chg_n;
            done         <= done_n;
            pass         <= pass_n;
            timeout      <= to_n;
            proc_reset   <= (state_n == S_IDLE) || (state_n == S_RESET);
            running      <= (state_n == S_RESET) || (state_n == S_RUN);
        end
    end

`ifdef MIPS_MON_HIST_EN
    logic [RESULT_W-1:0] hist_mem [HIST_DEPTH];
    logic [IW-1:0]       wptr;
    logic [IW-1:0]       rptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
        end else if (clr) begin
            wptr <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
        end else if (push) begin
            hist_mem[wptr] <= result;
            wptr           <= wptr + IW'(1);
        end
    end

    // wptr points at the next free slot; index 0 is the latest push
    assign rptr      = wptr - IW'(1) - hist_idx;
    assign hist_data = hist_mem[rptr];
`else
    logic unused_hist;
    assign unused_hist = ^{hist_idx, push, clr};
    assign hist_data   = '0;
`endif

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor at default parameters; inputs driven 1 time unit after each rising edge.
module tb_mips_run_monitor;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [16:0] expected, result;
    logic        proc_reset, running, done, pass, timeout;
    logic [15:0] cycle_count;
    logic [7:0]  change_count;
    logic [2:0]  hist_idx;
    logic [16:0] hist_data;

    int checks = 0;
    int errors = 0;

    mips_run_monitor dut (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .result(result),
        .proc_reset(proc_reset), .running(running), .done(done), .pass(pass),
        .timeout(timeout), .cycle_count(cycle_count), .change_count(change_count),
        .hist_idx(hist_idx), .hist_data(hist_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start and steps through the two RESET cycles; the next tick is RUN sample 1.
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic sample(input logic [16:0] v);
        result = v;
        tick();
    endtask

    task automatic check_final(input string tag, input logic p, input logic t,
                               input int cc, input int chg);
        check({tag, "_done"},    done, 1);
        check({tag, "_running"}, running, 0);
        check({tag, "_pass"},    pass, p);
        check({tag, "_timeout"}, timeout, t);
        check({tag, "_cc"},      cycle_count, cc);
        check({tag, "_chg"},     change_count, chg);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; expected = '0; result = '0; hist_idx = '0;
        tick();
        check("rst_proc_reset", proc_reset, 1);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_cc", cycle_count, 0);
        check("rst_hist", hist_data, 0);
        reset = 1'b0;
        tick();
        check("idle_proc_reset", proc_reset, 1);

        // Constant matching result: pass after STABLE_CYCLES samples
        expected = 17'h00005; result = 17'h00005;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s2_reset1_prst", proc_reset, 1);
        check("s2_reset1_running", running, 1);
        tick();
        check("s2_reset2_prst", proc_reset, 1);
        tick();
        check("s2_run_prst", proc_reset, 0);
        for (int i = 0; i < 3; i++) sample(17'h00005);
        check("s2_notyet_done", done, 0);
        sample(17'h00005);
        check_final("s2", 1, 0, 4, 0);
        check("s2_done_prst", proc_reset, 0);

        // Changing result then stable at expected
        expected = 17'd7;
        start_run();
        sample(17'd1); sample(17'd2); sample(17'd3);
        for (int i = 0; i < 4; i++) sample(17'd7);
        check_final("s3", 1, 0, 7, 3);
`ifdef MIPS_MON_HIST_EN
        hist_idx = 3'd0; #1 check("s3_hist0", hist_data, 7);
        hist_idx = 3'd1; #1 check("s3_hist1", hist_data, 3);
        hist_idx = 3'd3; #1 check("s3_hist3", hist_data, 1);
        hist_idx = 3'd4; #1 check("s3_hist4", hist_data, 0);
`else
        hist_idx = 3'd1; #1 check("s3_hist_off", hist_data, 0);
`endif
        hist_idx = 3'd0;

        // Toggling result: budget exhausted
        expected = 17'h1FFFF;
        start_run();
        for (int i = 0; i < 49; i++) sample(17'(i & 1));
        check("s4_notyet_done", done, 0);
        sample(17'd1);
        check_final("s4", 0, 1, 50, 49);

        // Pass decided on the same sample that exhausts the budget
        expected = 17'd9;
        start_run();
        for (int i = 0; i < 46; i++) sample(17'd3);
        sample(17'd9); sample(17'd9); sample(17'd9);
        check("s5_notyet_done", done, 0);
        sample(17'd9);
        check_final("s5", 1, 0, 50, 1);

        // start during RUN is ignored; restart from DONE clears counters
        expected = 17'h00005;
        start_run();
        start = 1'b1;
        sample(17'h00005);
        start = 1'b0;
        check("s6_ign_running", running, 1);
        check("s6_ign_cc", cycle_count, 1);
        for (int i = 0; i < 3; i++) sample(17'h00005);
        check_final("s6a", 1, 0, 4, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s6_restart_cc", cycle_count, 0);
        check("s6_restart_done", done, 0);
        check("s6_restart_pass", pass, 0);
        tick(); tick();
        for (int i = 0; i < 4; i++) sample(17'h00005);
        check_final("s6b", 1, 0, 4, 0);

        // Asynchronous reset mid-run
        expected = 17'd2;
        start_run();
        sample(17'd1); sample(17'd1);
        check("s1_pre_running", running, 1);
        reset = 1'b1;
        #1;
        check("s1_prst", proc_reset, 1);
        check("s1_running", running, 0);
        check("s1_done", done, 0);
        check("s1_pass", pass, 0);
        check("s1_timeout", timeout, 0);
        check("s1_cc", cycle_count, 0);
        start = 1'b1;
        tick(); tick();
        check("s1_start_ign", running, 0);
        start = 1'b0;
        reset = 1'b0;
        tick(); tick();
        check("s1_wait_start", running, 0);
        check("s1_wait_prst", proc_reset, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
